// File: rtl/max_sel_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max_sel_controller_pkg
// Description : Shared sizes, state encoding and class-index helper for the
//               10-class max-selector controller.
// Revision    : 1.0 - initial release
// ============================================================================
package max_sel_controller_pkg;

    localparam int NUM_CLASS = 10;
    localparam int SCORE_W   = 26;
    localparam int IDX_W     = 4;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASS - 1);

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_WAIT_SEL = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return idx <= C_LAST_IDX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_sel_score_bank.sv
`default_nettype none
// ============================================================================
// Module      : max_sel_score_bank
// Description : Score registers, per-class load mask and dup/idx error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module max_sel_score_bank
    import max_sel_controller_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic [SCORE_W-1:0]                 i_wr_score,
    input  logic [IDX_W-1:0]                   i_wr_idx,
    input  logic                               i_clear_mask,
    output logic [NUM_CLASS-1:0][SCORE_W-1:0]  o_bank,
    output logic                               o_full_after_wr,
    output logic                               o_idx_err,
    output logic                               o_dup_err
);

    logic [NUM_CLASS-1:0][SCORE_W-1:0] bank_d, bank_q;
    logic [NUM_CLASS-1:0]              mask_d, mask_q;
    logic                              idx_err_d, idx_err_q;
    logic                              dup_err_d, dup_err_q;
    logic [NUM_CLASS-1:0]              w_sel;
    logic                              w_in_range;
    logic                              w_wr_ok;

    always_comb begin
        w_in_range = idx_in_range(i_wr_idx);
        w_wr_ok    = i_wr_en & w_in_range;
        w_sel      = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            w_sel[i] = (i_wr_idx == IDX_W'(i));
        end

        bank_d = bank_q;
        mask_d = mask_q;
        if (w_wr_ok) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                if (w_sel[i]) begin
                    bank_d[i] = i_wr_score;
                end
            end
            mask_d = mask_q | w_sel;
        end
        // Clearing only happens on the result handshake, never alongside a write.
        if (i_clear_mask) begin
            mask_d = '0;
        end

        idx_err_d       = i_wr_en & ~w_in_range;
        dup_err_d       = w_wr_ok & (|(mask_q & w_sel));
        o_full_after_wr = w_wr_ok & (&(mask_q | w_sel));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q    <= '0;
            mask_q    <= '0;
            idx_err_q <= 1'b0;
            dup_err_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            mask_q    <= mask_d;
            idx_err_q <= idx_err_d;
            dup_err_q <= dup_err_d;
        end
    end

    assign o_bank    = bank_q;
    assign o_idx_err = idx_err_q;
    assign o_dup_err = dup_err_q;

endmodule
`default_nettype wire

// File: rtl/max_sel_controller.sv
`default_nettype none
// ============================================================================
// Module      : max_sel_controller
// Description : Collects ten class scores, waits out the max-selector latency
//               and hands the winning class downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module max_sel_controller
    import max_sel_controller_pkg::*;
#(
    parameter int SEL_LATENCY = 2,
    parameter int FRAME_W     = 16
) (
    input  logic               clk,
    input  logic               GlobalReset,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [IDX_W-1:0]   score_idx,
    input  logic               score_valid,
    output logic               score_ready,
    output logic [SCORE_W-1:0] Out_0,
    output logic [SCORE_W-1:0] Out_1,
    output logic [SCORE_W-1:0] Out_2,
    output logic [SCORE_W-1:0] Out_3,
    output logic [SCORE_W-1:0] Out_4,
    output logic [SCORE_W-1:0] Out_5,
    output logic [SCORE_W-1:0] Out_6,
    output logic [SCORE_W-1:0] Out_7,
    output logic [SCORE_W-1:0] Out_8,
    output logic [SCORE_W-1:0] Out_9,
    input  logic [IDX_W-1:0]   sel_class,
    output logic [IDX_W-1:0]   result_class,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               idx_err,
    output logic               dup_err,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int CNT_W = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SEL_LATENCY - 1);

    state_t             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [IDX_W-1:0]   result_class_d, result_class_q;
    logic               result_valid_d, result_valid_q;
    logic               score_ready_d, score_ready_q;
    logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;

    logic                              w_accept;
    logic                              w_handshake;
    logic                              w_clear_mask;
    logic                              w_full_after_wr;
    logic [NUM_CLASS-1:0][SCORE_W-1:0] w_bank;

    // score_ready is high exactly in COLLECT, so it alone gates acceptance.
    assign w_accept     = score_valid & score_ready_q;
    assign w_handshake  = result_valid_q & result_ready;
    assign w_clear_mask = (state_q == ST_HOLD) & w_handshake;

    max_sel_score_bank u_bank (
        .clk             (clk),
        .rst             (GlobalReset),
        .i_wr_en         (w_accept),
        .i_wr_score      (score_in),
        .i_wr_idx        (score_idx),
        .i_clear_mask    (w_clear_mask),
        .o_bank          (w_bank),
        .o_full_after_wr (w_full_after_wr),
        .o_idx_err       (idx_err),
        .o_dup_err       (dup_err)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_class_d = result_class_q;
        result_valid_d = result_valid_q;
        score_ready_d  = score_ready_q;
        frame_cnt_d    = frame_cnt_q;

        case (state_q)
            ST_COLLECT: begin
                if (w_accept && w_full_after_wr) begin
                    state_d       = ST_WAIT_SEL;
                    cnt_d         = C_CNT_LOAD;
                    score_ready_d = 1'b0;
                end
            end
            ST_WAIT_SEL: begin
                if (cnt_q == '0) begin
                    result_class_d = sel_class;
                    result_valid_d = 1'b1;
                    state_d        = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    result_valid_d = 1'b0;
                    frame_cnt_d    = frame_cnt_q + FRAME_W'(1);
                    score_ready_d  = 1'b1;
                    state_d        = ST_COLLECT;
                end
            end
            default: begin
                state_d        = ST_COLLECT;
                result_valid_d = 1'b0;
                score_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q        <= ST_COLLECT;
            cnt_q          <= '0;
            result_class_q <= '0;
            result_valid_q <= 1'b0;
            score_ready_q  <= 1'b1;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_class_q <= result_class_d;
            result_valid_q <= result_valid_d;
            score_ready_q  <= score_ready_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign score_ready  = score_ready_q;
    assign result_class = result_class_q;
    assign result_valid = result_valid_q;
    assign frame_cnt    = frame_cnt_q;

    assign Out_0 = w_bank[0];
    assign Out_1 = w_bank[1];
    assign Out_2 = w_bank[2];
    assign Out_3 = w_bank[3];
    assign Out_4 = w_bank[4];
    assign Out_5 = w_bank[5];
    assign Out_6 = w_bank[6];
    assign Out_7 = w_bank[7];
    assign Out_8 = w_bank[8];
    assign Out_9 = w_bank[9];

endmodule
`default_nettype wire

// File: tb/tb_max_sel_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_sel_controller
// Description : Directed, table-driven self-checking bench for the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_sel_controller;
    import max_sel_controller_pkg::*;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         GlobalReset;
    logic [25:0]  score_in;
    logic [3:0]   score_idx;
    logic         score_valid;
    logic         score_ready;
    logic [25:0]  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5, Out_6, Out_7, Out_8, Out_9;
    logic [3:0]   sel_class;
    logic [3:0]   result_class;
    logic         result_valid;
    logic         result_ready;
    logic         idx_err;
    logic         dup_err;
    logic [15:0]  frame_cnt;

    always #5 clk = ~clk;

    max_sel_controller #(.SEL_LATENCY(LAT), .FRAME_W(16)) dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .score_in(score_in), .score_idx(score_idx), .score_valid(score_valid),
        .score_ready(score_ready),
        .Out_0(Out_0), .Out_1(Out_1), .Out_2(Out_2), .Out_3(Out_3), .Out_4(Out_4),
        .Out_5(Out_5), .Out_6(Out_6), .Out_7(Out_7), .Out_8(Out_8), .Out_9(Out_9),
        .sel_class(sel_class), .result_class(result_class), .result_valid(result_valid),
        .result_ready(result_ready), .idx_err(idx_err), .dup_err(dup_err),
        .frame_cnt(frame_cnt)
    );

    logic [25:0] outs [10];
    assign outs[0] = Out_0;
    assign outs[1] = Out_1;
    assign outs[2] = Out_2;
    assign outs[3] = Out_3;
    assign outs[4] = Out_4;
    assign outs[5] = Out_5;
    assign outs[6] = Out_6;
    assign outs[7] = Out_7;
    assign outs[8] = Out_8;
    assign outs[9] = Out_9;

    // Stand-in for the max selector: argmax of the bank, lowest index wins ties.
    always_comb begin
        logic [25:0] best;
        best      = outs[0];
        sel_class = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (outs[i] > best) begin
                best      = outs[i];
                sel_class = 4'(i);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    logic [25:0] ref_bank [10];

    typedef struct {
        logic [3:0]  idx;
        logic [25:0] score;
        logic        exp_dup;
        logic        exp_ierr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_argmax();
        logic [25:0] best;
        logic [3:0]  k;
        best = ref_bank[0];
        k    = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (ref_bank[i] > best) begin
                best = ref_bank[i];
                k    = 4'(i);
            end
        end
        return k;
    endfunction

    task automatic check_bank(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (outs[i] !== ref_bank[i]) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Returns at the negedge following the accept edge.
    task automatic send(input logic [3:0] idx, input logic [25:0] score,
                        input logic exp_dup, input logic exp_ierr);
        int n;
        @(negedge clk);
        score_idx   = idx;
        score_in    = score;
        score_valid = 1'b1;
        n = 0;
        while (!score_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("score_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        if (idx < 4'd10) ref_bank[idx] = score;
        chk("dup_err", dup_err, exp_dup);
        chk("idx_err", idx_err, exp_ierr);
    endtask

    // Called right after the final send; n counts edges after the accept edge.
    task automatic await_result(input logic [3:0] exp_class, input logic check_lat);
        int n;
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("result_valid_timeout", 32'd0, 32'd1);
        if (check_lat) chk("result_latency", n, LAT);
        chk("result_class", result_class, exp_class);
        chk("score_ready_in_hold", score_ready, 1'b0);
    endtask

    task automatic complete(input logic [15:0] exp_frames);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        chk("result_valid_after_hs", result_valid, 1'b0);
        chk("score_ready_after_hs", score_ready, 1'b1);
        chk("frame_cnt", frame_cnt, exp_frames);
    endtask

    task automatic do_reset();
        @(negedge clk);
        GlobalReset = 1'b1;
        for (int i = 0; i < 10; i++) ref_bank[i] = '0;
        #1;
        chk("rst_score_ready", score_ready, 1'b1);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_result_class", result_class, 4'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_errs", {dup_err, idx_err}, 2'b00);
        check_bank("rst_bank");
        repeat (2) @(negedge clk);
        GlobalReset = 1'b0;
    endtask

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cycles;
        int valid_seen;
        logic [15:0] f0;

        // Out-of-order frame with a duplicate and an out-of-range index.
        tbl[0]  = '{4'd3,  26'h3FFFFFF, 1'b0, 1'b0};
        tbl[1]  = '{4'd3,  26'd5,       1'b1, 1'b0};
        tbl[2]  = '{4'd7,  26'd70,      1'b0, 1'b0};
        tbl[3]  = '{4'd12, 26'd999,     1'b0, 1'b1};
        tbl[4]  = '{4'd0,  26'd1,       1'b0, 1'b0};
        tbl[5]  = '{4'd1,  26'd2,       1'b0, 1'b0};
        tbl[6]  = '{4'd2,  26'd3,       1'b0, 1'b0};
        tbl[7]  = '{4'd4,  26'd4,       1'b0, 1'b0};
        tbl[8]  = '{4'd5,  26'd500,     1'b0, 1'b0};
        tbl[9]  = '{4'd6,  26'd6,       1'b0, 1'b0};
        tbl[10] = '{4'd8,  26'd8,       1'b0, 1'b0};
        tbl[11] = '{4'd9,  26'd9,       1'b0, 1'b0};

        GlobalReset  = 1'b0;
        score_in     = '0;
        score_idx    = '0;
        score_valid  = 1'b0;
        result_ready = 1'b0;
        do_reset();

        // In-order frame, latency check.
        for (int i = 0; i < 10; i++) begin
            send(4'(i), 26'((i + 1) * 10), 1'b0, 1'b0);
            if (i < 9) chk("inorder_still_collect", score_ready, 1'b1);
        end
        await_result(4'd9, 1'b1);
        check_bank("inorder_bank");
        complete(16'd1);

        // Reset mid-COLLECT with three scores loaded.
        send(4'd0, 26'd111, 1'b0, 1'b0);
        send(4'd1, 26'd222, 1'b0, 1'b0);
        send(4'd2, 26'd333, 1'b0, 1'b0);
        do_reset();
        for (int i = 9; i >= 0; i--) begin
            send(4'(i), (i == 4) ? 26'd900 : 26'(i), 1'b0, 1'b0);
        end
        await_result(4'd4, 1'b1);
        complete(16'd1);
        valid_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid) valid_seen++;
        end
        chk("post_reset_single_result", valid_seen, 0);

        // Table-driven duplicate / bad-index frame.
        for (int k = 0; k < 12; k++) begin
            send(tbl[k].idx, tbl[k].score, tbl[k].exp_dup, tbl[k].exp_ierr);
            check_bank("tbl_bank");
            if (k < 11) chk("tbl_still_collect", score_ready, 1'b1);
        end
        chk("tbl_out3", Out_3, 26'd5);
        await_result(4'd5, 1'b1);
        complete(16'd2);

        // Backpressure in HOLD, with score_valid driven against it.
        for (int i = 0; i < 10; i++) send(4'(i), 26'(1000 - i), 1'b0, 1'b0);
        await_result(4'd0, 1'b0);
        score_valid = 1'b1;
        score_idx   = 4'd0;
        score_in    = 26'h1234;
        bad_cycles  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result_class !== 4'd0 || score_ready !== 1'b0)
                bad_cycles++;
        end
        chk("backpressure_stable", bad_cycles, 0);
        check_bank("backpressure_bank");
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        score_valid  = 1'b0;
        chk("bp_score_ready_rise", score_ready, 1'b1);
        chk("bp_result_valid_low", result_valid, 1'b0);
        chk("bp_no_accept_at_hs", Out_0, 26'd1000);
        chk("bp_frame_cnt", frame_cnt, 16'd3);

        // Three back-to-back frames with result_ready held high.
        do_reset();
        result_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 10; i++) begin
                send(4'(i), 26'(((i + 3 * f) % 10) * 100 + 5), 1'b0, 1'b0);
            end
            await_result(ref_argmax(), 1'b1);
        end
        @(negedge clk);
        result_ready = 1'b0;
        f0 = frame_cnt;
        chk("b2b_frame_cnt", f0, 16'd3);
        chk("b2b_last_class", result_class, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
